// File: rtl/axi_sram_responder_pkg.sv
// Default wide-port AXI4 request/response structs for axi_sram_responder.
// Field names follow the cluster wide-port convention (aw/w/b/ar/r sub-structs
// plus per-channel valid/ready), so the cluster's own struct pair drops in.
package axi_sram_responder_pkg;

    localparam int unsigned AddrWidth = 48;
    localparam int unsigned DataWidth = 512;
    localparam int unsigned IdWidth   = 6;
    localparam int unsigned UserWidth = 1;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [UserWidth-1:0] user;
    } axi_ax_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
        logic [UserWidth-1:0]   user;
    } axi_w_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } axi_b_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        axi_b_t  b;
        logic    r_valid;
        axi_r_t  r;
    } axi_resp_t;

endpackage

// File: rtl/axi_sram_responder.sv
// AXI4 subordinate backed by an internal word-addressed SRAM. Serves one
// transaction at a time (read burst, or write burst plus B). NumWords must be
// a power of two. Define AXI_SRAM_RESPONDER_TRACE_EN to get a $display trace
// of accepted requests and completed responses; timing is unaffected.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | arbitrate AW vs AR (round robin on contention), latch request
// READ     | present R beats, one per r_ready handshake, no bubbles
// WRITE    | accept W beats, byte-strobed SRAM writes, collect errors
// WRESP    | hold B until b_ready, then back to IDLE
module axi_sram_responder #(
    parameter int unsigned          AddrWidth = 48,
    parameter int unsigned          DataWidth = 512,
    parameter int unsigned          IdWidth   = 6,
    parameter int unsigned          UserWidth = 1,
    parameter int unsigned          NumWords  = 1024,
    parameter logic [AddrWidth-1:0] BaseAddr  = 48'h8000_0000,
    parameter type                  axi_req_t  = axi_sram_responder_pkg::axi_req_t,
    parameter type                  axi_resp_t = axi_sram_responder_pkg::axi_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  axi_req_t  axi_req_i,
    output axi_resp_t axi_resp_o
);

    localparam int unsigned          StrbWidth = DataWidth / 8;
    localparam int unsigned          OffBits   = $clog2(StrbWidth);
    localparam int unsigned          IdxBits   = $clog2(NumWords);
    localparam logic [AddrWidth-1:0] SpanBytes = AddrWidth'(NumWords * StrbWidth);
    localparam logic [UserWidth-1:0] UserZero  = '0;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_WRESP = 2'd3;

    logic [DataWidth-1:0] mem [NumWords];

    logic [1:0]           state_q;
    logic                 rr_last_rd_q;
    logic [IdWidth-1:0]   id_q;
    logic [AddrWidth-1:0] addr_q;
    logic [7:0]           len_q;
    logic [2:0]           size_q;
    logic [1:0]           burst_q;
    logic [8:0]           beat_q;
    logic                 err_q;

    logic                 r_valid_q;
    logic [DataWidth-1:0] r_data_q;
    logic [1:0]           r_resp_q;
    logic                 r_last_q;

    logic                 grant_w, grant_r;
    logic                 r_hs, w_hs, b_hs;
    logic [8:0]           rd_next;
    logic [AddrWidth-1:0] rd_addr, rd_off, wr_addr, wr_off;
    logic                 rd_legal, rd_last, rd_ok, rd_load, wr_ok;
    logic [IdxBits-1:0]   rd_idx, wr_idx;
    logic                 beat_is_len;

    logic unused_user;
    assign unused_user = ^{axi_req_i.aw.user, axi_req_i.w.user, axi_req_i.ar.user};

    // FIXED keeps the start address; everything else steps by 2^size per beat.
    // WRAP/reserved are flagged illegal, so their address never reaches memory.
    function automatic logic [AddrWidth-1:0] calc_addr(input logic [AddrWidth-1:0] start,
                                                       input logic [8:0]           beat,
                                                       input logic [2:0]           size,
                                                       input logic [1:0]           burst);
        logic [AddrWidth-1:0] step;
        step = AddrWidth'(beat) << size;
        return (burst == BurstFixed) ? start : start + step;
    endfunction

    function automatic logic burst_legal(input logic [2:0] size, input logic [1:0] burst);
        return ((burst == BurstFixed) || (burst == BurstIncr)) && (32'(size) <= OffBits);
    endfunction

    // Arbitration: only in IDLE and out of reset; on contention the channel not served last wins.
    always_comb begin
        grant_w = 1'b0;
        grant_r = 1'b0;
        if (rst_ni && (state_q == ST_IDLE)) begin
            if (axi_req_i.aw_valid && axi_req_i.ar_valid) begin
                grant_w = rr_last_rd_q;
                grant_r = !rr_last_rd_q;
            end else begin
                grant_w = axi_req_i.aw_valid;
                grant_r = axi_req_i.ar_valid;
            end
        end
    end

    assign r_hs        = (state_q == ST_READ) && r_valid_q && axi_req_i.r_ready;
    assign w_hs        = (state_q == ST_WRITE) && axi_req_i.w_valid;
    assign b_hs        = (state_q == ST_WRESP) && axi_req_i.b_ready;
    assign beat_is_len = (beat_q == {1'b0, len_q});

    // Beat address, range check and word index for the next R beat and the current W beat.
    always_comb begin
        rd_next = beat_q + 9'd1;
        if (grant_r) begin
            rd_addr  = axi_req_i.ar.addr;
            rd_legal = burst_legal(axi_req_i.ar.size, axi_req_i.ar.burst);
            rd_last  = (axi_req_i.ar.len == 8'd0);
        end else begin
            rd_addr  = calc_addr(addr_q, rd_next, size_q, burst_q);
            rd_legal = burst_legal(size_q, burst_q);
            rd_last  = (rd_next == {1'b0, len_q});
        end
        rd_off  = rd_addr - BaseAddr;
        rd_ok   = rd_legal && (rd_off < SpanBytes);
        rd_idx  = rd_off[OffBits +: IdxBits];
        rd_load = grant_r || (r_hs && !r_last_q);

        wr_addr = calc_addr(addr_q, beat_q, size_q, burst_q);
        wr_off  = wr_addr - BaseAddr;
        wr_ok   = burst_legal(size_q, burst_q) && (wr_off < SpanBytes);
        wr_idx  = wr_off[OffBits +: IdxBits];
    end

    // Control FSM, latched request and registered R beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            rr_last_rd_q <= 1'b1;
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            beat_q       <= '0;
            err_q        <= 1'b0;
            r_valid_q    <= 1'b0;
            r_data_q     <= '0;
            r_resp_q     <= RespOkay;
            r_last_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_w) begin
                        id_q         <= axi_req_i.aw.id;
                        addr_q       <= axi_req_i.aw.addr;
                        len_q        <= axi_req_i.aw.len;
                        size_q       <= axi_req_i.aw.size;
                        burst_q      <= axi_req_i.aw.burst;
                        beat_q       <= '0;
                        rr_last_rd_q <= 1'b0;
                        state_q      <= ST_WRITE;
                    end else if (grant_r) begin
                        id_q         <= axi_req_i.ar.id;
                        addr_q       <= axi_req_i.ar.addr;
                        len_q        <= axi_req_i.ar.len;
                        size_q       <= axi_req_i.ar.size;
                        burst_q      <= axi_req_i.ar.burst;
                        beat_q       <= '0;
                        rr_last_rd_q <= 1'b1;
                        state_q      <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (r_hs) begin
                        if (r_last_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            beat_q <= rd_next;
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_hs) begin
                        if (!wr_ok || (axi_req_i.w.last && !beat_is_len)) begin
                            err_q <= 1'b1;
                        end
                        if (axi_req_i.w.last || beat_is_len) begin
                            state_q <= ST_WRESP;
                        end else begin
                            beat_q <= beat_q + 9'd1;
                        end
                    end
                end
                default: begin
                    if (b_hs) begin
                        err_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
            endcase

            if (rd_load) begin
                r_valid_q <= 1'b1;
                r_data_q  <= rd_ok ? mem[rd_idx] : '0;
                r_resp_q  <= rd_ok ? RespOkay : RespSlvErr;
                r_last_q  <= rd_last;
            end else if (r_hs) begin
                r_valid_q <= 1'b0;
                r_data_q  <= '0;
                r_resp_q  <= RespOkay;
                r_last_q  <= 1'b0;
            end
        end
    end

    // Byte-strobed SRAM write; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (w_hs && wr_ok) begin
            for (int b = 0; b < int'(StrbWidth); b++) begin
                if (axi_req_i.w.strb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= axi_req_i.w.data[b*8 +: 8];
                end
            end
        end
    end

    // Response channels; payloads read as zero whenever their valid is low.
    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = grant_w;
        axi_resp_o.ar_ready = grant_r;
        axi_resp_o.w_ready  = (state_q == ST_WRITE);
        axi_resp_o.b_valid  = (state_q == ST_WRESP);
        if (state_q == ST_WRESP) begin
            axi_resp_o.b.id   = id_q;
            axi_resp_o.b.resp = err_q ? RespSlvErr : RespOkay;
        end
        axi_resp_o.b.user   = UserZero;
        axi_resp_o.r_valid  = r_valid_q;
        axi_resp_o.r.id     = r_valid_q ? id_q : '0;
        axi_resp_o.r.data   = r_data_q;
        axi_resp_o.r.resp   = r_resp_q;
        axi_resp_o.r.last   = r_last_q;
        axi_resp_o.r.user   = UserZero;
    end

`ifdef AXI_SRAM_RESPONDER_TRACE_EN
    // Simulation trace of accepted requests and completed responses.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            if (grant_w) begin
                $display("%0t axi_sram W id=%0h addr=%0h len=%0d burst=%0d", $time,
                         axi_req_i.aw.id, axi_req_i.aw.addr, axi_req_i.aw.len, axi_req_i.aw.burst);
            end
            if (grant_r) begin
                $display("%0t axi_sram R id=%0h addr=%0h len=%0d burst=%0d", $time,
                         axi_req_i.ar.id, axi_req_i.ar.addr, axi_req_i.ar.len, axi_req_i.ar.burst);
            end
            if (b_hs) begin
                $display("%0t axi_sram B id=%0h resp=%0d", $time, id_q, err_q ? RespSlvErr : RespOkay);
            end
            if (r_hs && r_last_q) begin
                $display("%0t axi_sram R-last id=%0h resp=%0d", $time, id_q, r_resp_q);
            end
        end
    end
`else
    // Trace disabled: no simulation-only code in this build.
`endif

endmodule

// File: doc/axi_sram_responder.md
Name: axi_sram_responder

Overview:
- AXI4 subordinate on the cluster's wide port. It terminates requests from snitch_cluster_wrapper wide_out_req_o/wide_out_resp_i entirely in RTL, with no Renode bus_peripheral.
- Backed by an internal word-addressed SRAM array.
- Used for standalone Verilator bring-up of the cluster. It is a drop-in alternative to renode_memory on the same req/resp struct pair.
- Serves one transaction at a time: a read burst, or a write burst plus its B response.

Parameters:
- AddrWidth, 48, AXI address width (top_isolde_pkg::AddrWidth).
- DataWidth, 512, AXI data width (top_isolde_pkg::DataWidth).
- IdWidth, 6, AXI ID width (top_isolde_pkg::IdWidthIn).
- UserWidth, 1, AXI user width. User bits are ignored and returned as 0.
- NumWords, 1024, SRAM depth in DataWidth-bit words. Must be a power of two.
- BaseAddr, 48'h8000_0000, byte address of word 0.
- axi_req_t, snitch_cluster_pkg wide request type, request struct.
- axi_resp_t, snitch_cluster_pkg wide response type, response struct.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- axi_req_i  in  axi_req_t  AW/W/AR channels plus b_ready/r_ready.
- axi_resp_o  out  axi_resp_t  aw/w/ar ready, B and R channels.

Behaviour:
- Reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
  - While rst_ni=0: all ready/valid outputs are 0, FSM=IDLE, rr_last=READ, and all B/R payload fields are 0.
  - SRAM contents are not reset.
- Reset mid-burst: the burst is abandoned immediately and no further beats or B are issued. Memory writes already committed remain.
- FSM states: IDLE, READ, WRITE, WRESP.
- IDLE:
  - aw_ready=ar_ready=1 only when the arbiter grants that channel; w_ready=0.
  - If both aw_valid and ar_valid are high, grant the channel opposite rr_last, then update rr_last.
  - Only one channel is accepted per cycle.
  - On acceptance, latch id, addr, len, size and burst.
  - Beat counter = 0; next state is READ or WRITE.
- Address computation:
  - Beat address for INCR = latched addr + beat*2^size.
  - Beat address for FIXED = latched addr.
  - Word index = (beat_addr-BaseAddr)>>log2(DataWidth/8), truncated to log2(NumWords) bits.
  - A beat is in range iff BaseAddr <= beat_addr < BaseAddr + NumWords*DataWidth/8.
- Burst type WRAP(2'b10) or reserved(2'b11):
  - The burst completes normally in terms of beat count.
  - Every beat is SLVERR and memory is not accessed.
- READ:
  - r_valid asserts the cycle after AR acceptance, i.e. 1-cycle first-beat latency.
  - r_data = SRAM[word index] registered; r_id = latched id.
  - r_resp = OKAY, or SLVERR if the beat is out of range (r_data=0 in that case).
  - r_last = (beat==len).
  - r_valid holds with payload stable until r_ready.
  - On each r_valid&&r_ready: beat++ and the next beat is presented the next cycle, without a bubble.
  - The last beat's handshake returns the FSM to IDLE.
- WRITE:
  - w_ready=1; aw_ready=ar_ready=0.
  - Each w_valid&&w_ready writes w_data bytes where w_strb=1 to the word index.
  - Write only if the beat is in range and the burst is legal. A beat with zero strobe writes nothing.
  - Any failed beat sets a sticky err flag.
  - The beat with w_last=1, or beat==len, goes to WRESP. Excess beats are never accepted.
  - An early w_last before beat==len also ends the burst and sets err.
- WRESP:
  - b_valid=1, b_id = latched id, b_resp = SLVERR if err, else OKAY.
  - Held until b_ready, then return to IDLE and clear err.
  - The next AW/AR can be accepted at the earliest in the cycle after the B handshake.
- Read-after-write: a read accepted after B returns the written data.
- Widths:
  - len is 8 bits, giving 1..256 beats; the beat counter is 9 bits.
  - size greater than log2(DataWidth/8) is treated as SLVERR per beat.
  - Address arithmetic is AddrWidth wide and wraps modulo 2^AddrWidth. A wrapped address falls out of range and gives SLVERR.

Optional Feature:
- AXI_SRAM_RESPONDER_TRACE_EN defined:
  - Each accepted AW/AR prints time, R/W, id, addr, len, burst via $display.
  - Each completed B and each last R beat prints id and resp.
  - Adds no ports and does not change timing.
- Undefined: no $display code is compiled and behaviour is identical.

Test Plan:
- Single-beat write then read:
  - Stimulus: AW addr=BaseAddr+0x40, len=0, size=6, INCR, id=3, data=all 0xA5, strb=all 1s; then AR same addr, id=5.
  - Required: B id=3 OKAY; R 1 cycle after AR accept, id=5, data all 0xA5, last=1, OKAY.
- INCR burst with backpressure:
  - Stimulus: write len=3 at word 8 with data 1,2,3,4; read len=3 with r_ready toggling every other cycle.
  - Required: R beats 1,2,3,4 in order, payload stable while stalled, last only on beat 3.
- Byte strobes:
  - Stimulus: write word 0 all 0xFF; then write with strb=0x...0001 and data byte0=0x12.
  - Required: readback byte0=0x12, all other bytes 0xFF.
- Out-of-range:
  - Stimulus: AR at BaseAddr+NumWords*64, len=1; and AW at BaseAddr-64.
  - Required: both R beats SLVERR with data 0; B SLVERR; memory unchanged.
- Simultaneous AW and AR valid in the same cycle, twice:
  - Required: first grant READ is not given (rr_last=READ after reset, so WRITE wins); second grant goes to READ.
  - Required: no transaction is lost and IDs are matched.
- Reset mid-burst:
  - Stimulus: assert rst_ni=0 asynchronously during a len=7 read after beat 2.
  - Required: r_valid=0 in the same cycle; after release, FSM=IDLE and a new AR is served normally.
